// File: rtl/cad_ca1_pkg.sv
// Shared constants and FSM state type for the bit-plane accumulator slice.
package cad_ca1_pkg;

    localparam int N_WORDS  = 64;
    localparam int WORD_W   = 25;
    localparam int SUM_W    = WORD_W + $clog2(N_WORDS);
    localparam int PIPE_LAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/popcount64.sv
// Combinational population count of one bit-plane (one bit per stored word).
module popcount64 #(
    parameter  int N_WORDS = 64,
    localparam int CNT_W   = $clog2(N_WORDS + 1)
) (
    input  logic [N_WORDS-1:0] bits,
    output logic [CNT_W-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/bitplane_accumulator.sv
// Sums N_WORDS unsigned words by requesting one bit-plane at a time, MSB first,
// and folding each plane's popcount into a shift-and-add accumulator.
module bitplane_accumulator #(
    parameter  int N_WORDS  = cad_ca1_pkg::N_WORDS,
    parameter  int WORD_W   = cad_ca1_pkg::WORD_W,
    parameter  int PIPE_LAT = cad_ca1_pkg::PIPE_LAT,
    localparam int SUM_W    = WORD_W + $clog2(N_WORDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               read_data,
    output logic [4:0]         num,
    input  logic [N_WORDS-1:0] pipe,
    output logic               busy,
    output logic               done,
    output logic [SUM_W-1:0]   sum
);

    import cad_ca1_pkg::state_t;
    import cad_ca1_pkg::IDLE;
    import cad_ca1_pkg::REQ;
    import cad_ca1_pkg::WAIT;
    import cad_ca1_pkg::ACC;
    import cad_ca1_pkg::DONE;

    localparam int K_W    = 5;
    localparam int WAIT_W = 3;
    localparam int CNT_W  = $clog2(N_WORDS + 1);

    state_t              state;
    state_t              state_n;
    logic [K_W-1:0]      k;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [SUM_W-1:0]    acc;
    logic [SUM_W-1:0]    acc_n;
    logic [CNT_W-1:0]    pop_cnt;
    logic                last_plane;

    popcount64 #(.N_WORDS(N_WORDS)) u_popcount (
        .bits  (pipe),
        .count (pop_cnt)
    );

    // Planes arrive MSB first, so doubling before adding gives each plane its weight.
    assign acc_n      = (acc << 1) + SUM_W'(pop_cnt);
    assign last_plane = (k == K_W'(WORD_W - 1));
    assign num        = k;
    assign busy       = (state != IDLE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = REQ;
            REQ:     state_n = WAIT;
            WAIT:    if (wait_cnt == WAIT_W'(PIPE_LAT - 1)) state_n = ACC;
            ACC:     state_n = last_plane ? DONE : REQ;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with REQ and DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            wait_cnt  <= '0;
            acc       <= '0;
            sum       <= '0;
            read_data <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            read_data <= (state_n == REQ);
            done      <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        k   <= '0;
                    end
                end
                REQ:  wait_cnt <= '0;
                WAIT: wait_cnt <= wait_cnt + WAIT_W'(1);
                ACC: begin
                    acc <= acc_n;
                    if (last_plane) begin
                        sum <= acc_n;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitplane_accumulator.sv
// Directed bench for bitplane_accumulator with a behavioural upstream plane reader.
module tb_bitplane_accumulator;

    localparam int N_WORDS  = 64;
    localparam int WORD_W   = 25;
    localparam int PIPE_LAT = 2;
    localparam int SUM_W    = 31;
    localparam int TIMEOUT  = 300;

    logic               clk;
    logic               rst;
    logic               start;
    logic               read_data;
    logic [4:0]         num;
    logic [N_WORDS-1:0] pipe;
    logic               busy;
    logic               done;
    logic [SUM_W-1:0]   sum;

    logic [WORD_W-1:0]  words [N_WORDS];

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    bitplane_accumulator #(
        .N_WORDS  (N_WORDS),
        .WORD_W   (WORD_W),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .read_data (read_data),
        .num       (num),
        .pipe      (pipe),
        .busy      (busy),
        .done      (done),
        .sum       (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N_WORDS-1:0] plane_of(input int n);
        logic [N_WORDS-1:0] p;
        for (int i = 0; i < N_WORDS; i++) begin
            p[i] = words[i][WORD_W-1-n];
        end
        return p;
    endfunction

    // Upstream reader: junk on the bus until the requested plane lands PIPE_LAT edges later.
    initial begin
        logic   rd_seen;
        logic [4:0] rd_num;
        logic [4:0] saved_num;
        int     cd;
        cd        = 0;
        saved_num = '0;
        pipe      = '0;
        forever begin
            @(posedge clk);
            rd_seen = read_data;
            rd_num  = num;
            #1;
            if (cd > 0) begin
                cd--;
                if (cd == 0) pipe = plane_of(int'(saved_num));
            end
            if (rd_seen) begin
                saved_num = rd_num;
                cd        = PIPE_LAT;
                pipe      = {$urandom(), $urandom()};
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic setWords(input int mode);
        for (int i = 0; i < N_WORDS; i++) begin
            case (mode)
                0: words[i] = '0;
                1: words[i] = 25'h1FFFFFF;
                2: words[i] = WORD_W'(i);
                3: words[i] = (i == 5) ? WORD_W'(1) : '0;
                default: words[i] = WORD_W'(3 * i);
            endcase
        end
    endtask

    // Pulses start once and follows the run to done; edge 0 is the edge that samples start.
    task automatic applyStimulus(output int done_edge, output int pulses, output bit order_ok,
                                 output logic [SUM_W-1:0] sum_at_start);
        done_edge = -1;
        pulses    = 0;
        order_ok  = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        sum_at_start = sum;
        for (int e = 0; e <= TIMEOUT && done_edge < 0; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            if (read_data) begin
                if (num !== 5'(pulses)) order_ok = 1'b0;
                pulses++;
            end
            if (done) done_edge = e;
        end
    endtask

    initial begin
        int                done_edge;
        int                pulses;
        bit                order_ok;
        logic [SUM_W-1:0]  sum_at_start;
        bit                found;
        bit                saw_done;
        int                dones;
        int                first_done;
        logic              busy_after;

        rst   = 1'b1;
        start = 1'b0;
        setWords(0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_read_data", 64'(read_data), 64'd0);
        checkOutput("reset_busy",      64'(busy),      64'd0);
        checkOutput("reset_done",      64'(done),      64'd0);
        checkOutput("reset_num",       64'(num),       64'd0);
        checkOutput("reset_sum",       64'(sum),       64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] all-zero words");
        applyStimulus(done_edge, pulses, order_ok, sum_at_start);
        checkOutput("zero_done_edge", 64'(done_edge), 64'd100);
        checkOutput("zero_sum",       64'(sum),       64'd0);
        checkOutput("zero_pulses",    64'(pulses),    64'd25);
        checkOutput("zero_num_order", 64'(order_ok),  64'd1);
        checkOutput("zero_busy_in_done", 64'(busy),   64'd1);
        @(posedge clk);
        #1;
        checkOutput("zero_busy_after", 64'(busy), 64'd0);
        checkOutput("zero_done_after", 64'(done), 64'd0);

        $display("[TB] all-ones words");
        setWords(1);
        applyStimulus(done_edge, pulses, order_ok, sum_at_start);
        checkOutput("ones_sum",       64'(sum),       64'd2147483584);
        checkOutput("ones_done_edge", 64'(done_edge), 64'd100);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] word n = n");
        setWords(2);
        applyStimulus(done_edge, pulses, order_ok, sum_at_start);
        checkOutput("ramp_sum", 64'(sum), 64'd2016);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ramp_sum_held", 64'(sum), 64'd2016);

        $display("[TB] single LSB in word 5");
        setWords(3);
        applyStimulus(done_edge, pulses, order_ok, sum_at_start);
        checkOutput("lsb_sum_at_start", 64'(sum_at_start), 64'd2016);
        checkOutput("lsb_sum",          64'(sum),          64'd1);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset during plane 10");
        setWords(2);
        found    = 1'b0;
        saw_done = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 0; e < TIMEOUT && !found; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            if (done) saw_done = 1'b1;
            if (read_data && num == 5'd10) found = 1'b1;
        end
        checkOutput("mid_reached_plane10", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_num",  64'(num),  64'd0);
        checkOutput("mid_rst_sum",  64'(sum),  64'd0);
        for (int e = 0; e < 120; e++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        checkOutput("mid_no_done", 64'(saw_done), 64'd0);
        applyStimulus(done_edge, pulses, order_ok, sum_at_start);
        checkOutput("mid_restart_pulses", 64'(pulses),    64'd25);
        checkOutput("mid_restart_order",  64'(order_ok),  64'd1);
        checkOutput("mid_restart_sum",    64'(sum),       64'd2016);
        checkOutput("mid_restart_edge",   64'(done_edge), 64'd100);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] start during WAIT and DONE");
        setWords(4);
        dones      = 0;
        first_done = -1;
        busy_after = 1'b1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 1; e <= 250; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (first_done >= 0 && e == first_done + 1) busy_after = busy;
            if (e == 2) start = 1'b1;
            if (done) begin
                dones++;
                if (first_done < 0) begin
                    first_done = e;
                    start      = 1'b1;
                end
            end
        end
        start = 1'b0;
        checkOutput("ignore_done_count", 64'(dones),      64'd1);
        checkOutput("ignore_done_edge",  64'(first_done), 64'd100);
        checkOutput("ignore_sum",        64'(sum),        64'd6048);
        checkOutput("ignore_busy_after", 64'(busy_after), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
